// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. Bytes are drained one at a time as tx_enable pulses,
// and a fixed gap between pulses covers one full frame because the UART has no busy flag.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int BYTE_CYCLES = 1100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_byte,
    output logic              tx_enable
);

    localparam int                GAP_W    = $clog2(BYTE_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(BYTE_CYCLES - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic [7:0]        r_tx_byte;
    logic [GAP_W-1:0]  r_gap;
    state_t            r_state;

    state_t            w_state_next;
    logic              w_wr;
    logic              w_pop;
    logic              w_gap_load;
    logic [ADDR_W:0]   w_count_next;

    // full is the registered flag from the start of the cycle, so a pop in the same cycle
    // does not open a slot for the incoming byte.
    assign w_wr = wr_en && !r_full;

    // NOTE: the storage array has no reset; the pointers and count alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_gap_load   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop        = 1'b1;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                w_gap_load   = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_state_next = r_empty ? S_IDLE : S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_full     <= (w_count_next == FULL_CNT);
            r_empty    <= (w_count_next == '0);
            r_overflow <= wr_en && r_full;
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp      <= r_rp + 1'b1;
                r_tx_byte <= r_mem[r_rp];
            end
            // The gap is loaded in SEND and leaves WAIT at 1, giving BYTE_CYCLES+1 between pulses.
            if (w_gap_load) begin
                r_gap <= GAP_INIT;
            end else if (r_state == S_WAIT && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign tx_byte   = r_tx_byte;
    assign tx_enable = (r_state == S_SEND);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a short pulse gap (BYTE_CYCLES=20).
// Outputs are sampled on the falling edge; a monitor logs every tx_enable pulse.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int BC     = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_byte;
    logic              tx_enable;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_CYCLES(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_byte   (tx_byte),
        .tx_enable (tx_enable)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] b;
        int         c;
        int         cnt;
    } pulse_t;

    pulse_t pulses[$];
    int     last_pulse = -1;
    logic   prev_en    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Records every pulse and checks pulse width and minimum spacing as they happen.
    always @(negedge clk) begin
        if (rst) begin
            last_pulse = -1;
        end else if (tx_enable) begin
            check("single_cycle_pulse", prev_en, 1'b0);
            if (last_pulse >= 0) begin
                check("min_spacing", (cyc - last_pulse) >= BC, 1'b1);
            end
            last_pulse = cyc;
            pulses.push_back('{tx_byte, cyc, int'(count)});
        end
        prev_en = tx_enable;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_enable) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         base;
        int         mc;
        int         sent;
        int         drops;
        bit         wrote;
        bit         acc;
        logic [7:0] d;
        logic [7:0] expq[$];

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: pulse two cycles after the write edge.
        write_byte(8'hA5);
        check("t1_empty_fall", empty, 0);
        check("t1_count1", count, 1);
        check("t1_no_pulse_n", tx_enable, 0);
        @(negedge clk);
        check("t1_no_pulse_load", tx_enable, 0);
        @(negedge clk);
        check("t1_pulse", tx_enable, 1);
        check("t1_byte", tx_byte, 8'hA5);
        check("t1_empty_after_pop", empty, 1);
        check("t1_count0", count, 0);
        @(negedge clk);
        check("t1_pulse_end", tx_enable, 0);
        check("t1_byte_held", tx_byte, 8'hA5);
        idle(25);

        // Three back-to-back writes: pulses 21 cycles apart, count 2,1,0 at the pulses.
        base    = pulses.size();
        wr_en   = 1'b1;
        wr_data = 8'h01;
        @(negedge clk);
        check("t2_count_a", count, 1);
        wr_data = 8'h02;
        @(negedge clk);
        check("t2_count_b", count, 2);
        wr_data = 8'h03;
        @(negedge clk);
        check("t2_count_c", count, 2);
        wr_en = 1'b0;
        idle(50);
        check("t2_n_pulses", pulses.size() - base, 3);
        if (pulses.size() - base == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t2_byte", pulses[base+i].b, 8'(i + 1));
                check("t2_count_at_pulse", pulses[base+i].cnt, 2 - i);
                if (i > 0) check("t2_spacing", pulses[base+i].c - pulses[base+i-1].c, BC + 1);
            end
        end
        idle(25);

        // Fill 17 bytes while the FSM waits, then write on the LOAD cycle while full.
        write_byte(8'hEE);
        wait_pulse(10, ok);
        check("t3_dummy_pulse_seen", ok, 1);
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = (i == 16) ? 8'hFF : 8'(8'h10 + i);
            @(negedge clk);
            if (i == 14) check("t3_not_full_15", full, 0);
            if (i == 15) begin
                check("t3_full_16", full, 1);
                check("t3_count_16", count, 16);
                check("t3_no_ovf_16", overflow, 0);
            end
        end
        wr_en = 1'b0;
        check("t3_overflow", overflow, 1);
        check("t3_count_after_drop", count, 16);
        base = pulses.size();
        @(negedge clk);
        check("t3_overflow_one_cycle", overflow, 0);
        idle(2);
        wr_en   = 1'b1;
        wr_data = 8'hFE;
        @(negedge clk);
        wr_en = 1'b0;
        check("t4_overflow", overflow, 1);
        check("t4_count", count, DEPTH - 1);
        check("t4_full_clear", full, 0);
        check("t4_pulse", tx_enable, 1);
        check("t4_first_byte", tx_byte, 8'h10);
        idle(400);
        check("t3_n_pulses", pulses.size() - base, 16);
        if (pulses.size() - base == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("t3_order", pulses[base+i].b, 8'(8'h10 + i));
            end
        end
        check("t3_empty_after_drain", empty, 1);

        // Reset while waiting with 5 bytes queued.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h20 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("t5_count_before_rst", count, 5);
        rst = 1'b1;
        #1;
        check("t5_rst_count", count, 0);
        check("t5_rst_empty", empty, 1);
        check("t5_rst_full", full, 0);
        check("t5_rst_tx_enable", tx_enable, 0);
        @(negedge clk);
        rst  = 1'b0;
        base = pulses.size();
        idle(3 * BC);
        check("t5_no_pulse_after_rst", pulses.size() - base, 0);
        check("t5_still_empty", empty, 1);
        write_byte(8'h77);
        wait_pulse(10, ok);
        check("t5_new_pulse_seen", ok, 1);
        check("t5_new_byte", tx_byte, 8'h77);
        idle(25);

        // One write every BC/2 cycles for 40 bytes against a counting model.
        check("t6_start_count", count, 0);
        base  = pulses.size();
        mc    = 0;
        sent  = 0;
        drops = 0;
        for (int k = 0; k < 850; k++) begin
            wrote = (k % (BC / 2) == 0) && (sent < 40);
            d     = 8'(8'h40 + sent);
            if (wrote) begin
                wr_en   = 1'b1;
                wr_data = d;
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            acc = wrote && (mc < DEPTH);
            mc  = mc + int'(acc) - int'(tx_enable);
            if (wrote) begin
                if (acc) expq.push_back(d);
                else drops++;
                check("t6_overflow", overflow, !acc);
                check("t6_count", count, mc);
            end
        end
        wr_en = 1'b0;
        check("t6_drops_seen", drops > 0, 1);
        check("t6_n_pulses", pulses.size() - base, expq.size());
        if (pulses.size() - base == expq.size()) begin
            for (int i = 0; i < expq.size(); i++) begin
                check("t6_order", pulses[base+i].b, expq[i]);
            end
        end
        check("t6_empty_end", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
